// File: rtl/logiccore9_sequencer_if.sv
// logiccore9_sequencer_if
// Bundles the sequencer's request/stall/abort inputs and its step-code and
// status outputs. The master modport is the requester side, the slave
// modport is the sequencer itself.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds the 'step' qualifier.
interface logiccore9_sequencer_if #(
    parameter int CNT_W = 8
) ();

    logic             start;
    logic             hold;
    logic             abort;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
`endif
    logic [3:0]       q;
    logic             ctrl_en;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] run_cnt;

    modport master (
        output start,
        output hold,
        output abort,
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        input  q,
        input  ctrl_en,
        input  busy,
        input  done,
        input  aborted,
        input  run_cnt
    );

    modport slave (
        input  start,
        input  hold,
        input  abort,
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        output q,
        output ctrl_en,
        output busy,
        output done,
        output aborted,
        output run_cnt
    );

endinterface : logiccore9_sequencer_if

// File: rtl/logiccore9_sequencer.sv
// logiccore9_sequencer
// Four-state step sequencer (IDLE -> LOAD -> EXEC -> FIN -> IDLE) that walks
// a 4-bit step code q from 0 up to LAST_STATE for the control decoder, with
// stall (hold), abort and a saturating completed-operation counter.
// All outputs come straight from flops or from a decode of the state flop.
// Optional feature macro: SEQ_SINGLE_STEP_EN -- when defined, LOAD/EXEC only
// advance in cycles where step=1 (and hold=0).
module logiccore9_sequencer #(
    parameter int LAST_STATE = 13,
    parameter int CNT_W      = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    logiccore9_sequencer_if.slave bus
);

    // Three state bits so that encodings 4..7 exist and are explicitly
    // steered back to IDLE instead of being silently aliased.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_FIN  = 3'd3;

    localparam logic [3:0]       LAST_Q  = 4'(LAST_STATE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state_q,   state_d;
    logic [3:0]       q_q,       q_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

    logic [3:0]       q_inc;
    logic             advance;

    assign q_inc = q_q + 4'd1;

    // Decide whether LOAD/EXEC may move to the next step code this cycle.
    always_comb begin
`ifdef SEQ_SINGLE_STEP_EN
        advance = !bus.hold && bus.step;
`else
        advance = !bus.hold;
`endif
    end

    // Next-state, step-code, abort-pulse and counter computation.
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave
        // one unassigned and infer a latch.
        state_d   = state_q;
        q_d       = q_q;
        aborted_d = 1'b0;
        run_cnt_d = run_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                q_d = 4'd0;
                // abort outranks start; in IDLE it simply blocks the request
                if (bus.start && !bus.abort) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    q_d       = 4'd0;
                    aborted_d = 1'b1;
                end else if (advance) begin
                    // LOAD always holds q=0, so the next code is 1
                    q_d     = 4'd1;
                    state_d = (LAST_Q == 4'd1) ? ST_FIN : ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    q_d       = 4'd0;
                    aborted_d = 1'b1;
                end else if (q_q == 4'd0 || q_q >= LAST_Q) begin
                    // step code outside 1..LAST_STATE-1 cannot occur in EXEC;
                    // drop back to IDLE rather than run past LAST_STATE
                    state_d = ST_IDLE;
                    q_d     = 4'd0;
                end else if (advance) begin
                    q_d     = q_inc;
                    state_d = (q_inc == LAST_Q) ? ST_FIN : ST_EXEC;
                end
            end

            ST_FIN: begin
                // FIN is exactly one cycle; hold and step have no effect here
                state_d = ST_IDLE;
                q_d     = 4'd0;
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end else if (run_cnt_q != CNT_MAX) begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                q_d     = 4'd0;
            end
        endcase
    end

    // State, step-code, abort-pulse and counter registers.
    always_ff @(posedge clk) begin
        // NOTE: rst_n is tested inside the clocked block, so reset is
        // synchronous; non-blocking assignments make every flop sample the
        // values that were present before the edge.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            q_q       <= 4'd0;
            aborted_q <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            aborted_q <= aborted_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // Outputs: flops directly, or decodes of the state flop only.
    assign bus.q       = q_q;
    assign bus.ctrl_en = (state_q == ST_LOAD) || (state_q == ST_EXEC) ||
                         (state_q == ST_FIN);
    assign bus.busy    = (state_q == ST_LOAD) || (state_q == ST_EXEC) ||
                         (state_q == ST_FIN);
    assign bus.done    = (state_q == ST_FIN);
    assign bus.aborted = aborted_q;
    assign bus.run_cnt = run_cnt_q;

endmodule : logiccore9_sequencer

// File: doc/logiccore9_sequencer.md
LOGICCORE9_SEQUENCER -- requirements
Module: logiccore9_sequencer

Interface
REQ-001 The block SHALL provide parameter LAST_STATE, default 13, meaning the final step code, which the downstream decoder decodes as DONE.
REQ-002 The block SHALL provide parameter CNT_W, default 8, meaning the width of the completed-operation counter.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 start  input  1  operation request, sampled only in IDLE.
REQ-007 hold  input  1  stall; freezes the step code during LOAD/EXEC.
REQ-008 abort  input  1  terminates the current operation.
REQ-009 q  output  4  step code driven to the control decoder.
REQ-010 ctrl_en  output  1  high when q is valid, i.e. in any state other than IDLE.
REQ-011 busy  output  1  high in LOAD, EXEC and FIN.
REQ-012 done  output  1  one-cycle pulse in FIN.
REQ-013 aborted  output  1  one-cycle pulse in the cycle after an accepted abort.
REQ-014 run_cnt  output  CNT_W  count of completed operations, saturating.

Function
REQ-015 The FSM SHALL have four states:
- IDLE: q=0, ctrl_en=0.
- LOAD: q=0.
- EXEC: q=1..LAST_STATE-1.
- FIN: q=LAST_STATE.
REQ-016 In IDLE, start=1 and abort=0 SHALL move the FSM to LOAD in the next cycle, with ctrl_en=1 and busy=1.
REQ-017 In LOAD or EXEC with hold=0, q SHALL increment by 1 per cycle. LOAD SHALL go to EXEC, and EXEC SHALL go to FIN when the next q equals LAST_STATE.
REQ-018 In LOAD or EXEC with hold=1, q and the state SHALL be unchanged. A hold of any length SHALL be allowed.
REQ-019 FIN SHALL last exactly one cycle regardless of hold: done=1, then IDLE in the next cycle with q=0, ctrl_en=0, busy=0.
REQ-020 Latency: with start accepted at cycle n and no hold, q=0 at n+1, q=LAST_STATE and done at n+1+LAST_STATE, and busy low at n+2+LAST_STATE.
REQ-021 start SHALL be ignored outside IDLE. At least one IDLE cycle SHALL separate consecutive operations.
REQ-022 abort=1 in LOAD, EXEC or FIN SHALL force IDLE, q=0, ctrl_en=0 in the next cycle, with aborted=1 for that one cycle.
REQ-023 abort in FIN SHALL suppress run_cnt increment; done still pulses in that FIN cycle.
REQ-024 abort SHALL have priority over hold and start. In IDLE, abort=1 with start=1 SHALL remain IDLE with no aborted pulse.
REQ-025 run_cnt SHALL increment by 1 on each FIN cycle without abort and SHALL saturate at all-ones, with no wrap.
REQ-026 q SHALL never exceed LAST_STATE. Any illegal state encoding SHALL recover to IDLE in the next cycle.
REQ-027 All outputs SHALL be registered or decoded only from registered state, with no combinational path from an input to an output.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, q=0, ctrl_en=0, busy=0, done=0, aborted=0, run_cnt=0, including mid-operation.
REQ-029 The first start SHALL be accepted no earlier than the first edge with rst_n=1.

Configuration
REQ-030 Macro SEQ_SINGLE_STEP_EN, when defined, SHALL add input step (1 bit). In LOAD/EXEC, q SHALL advance only in cycles with step=1 and hold=0; FIN still lasts one cycle.
REQ-031 Without SEQ_SINGLE_STEP_EN, the step port SHALL be absent and advance SHALL follow REQ-017.

Verification
REQ-032 Reset, start pulse at cycle 5, no hold -> q steps 0..13 at cycles 6..19, done=1 only at cycle 19, busy=0 at 20, run_cnt=1.
REQ-033 hold=1 for 3 cycles while q=4 -> q stays 4 for 4 cycles total, done 3 cycles later than in REQ-032.
REQ-034 abort while q=7 -> next cycle q=0, ctrl_en=0, aborted=1, run_cnt unchanged; a new start is then accepted normally.
REQ-035 start held high continuously with CNT_W=2 over 5 operations -> each op separated by one IDLE cycle, run_cnt sequence 1,2,3,3,3.
REQ-036 rst_n=0 while q=10 -> next cycle all outputs at reset values. abort+start in IDLE -> stays IDLE, no aborted pulse.
REQ-037 With SEQ_SINGLE_STEP_EN defined, step pulsed every 3rd cycle -> q advances once per pulse and done follows the 13th advance.
